ifetch_unit: RTL and testbench

//   Instruction fetch unit: owns the PC and acts as the initiator of the

---
 rtl/ifu_pkg.sv | 19 +
 rtl/ifu_skid_fifo.sv | 55 +++++
 rtl/ifetch_unit.sv | 83 ++++++++
 tb/tb_ifetch_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional perf counters are enabled with IFU_PERF_CNT_EN (see ifetch_unit).
package ifu_pkg;

   localparam int unsigned XLEN         = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] INS_NOP      = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] ins;
   } ifu_entry_t;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } ifu_state_e;

endpackage

// File: rtl/ifu_skid_fifo.sv
// Two-entry FIFO of fetched {pc, ins} pairs between the ROM and decode.
// The caller never pushes when full without a pop, and never pops when empty.
module ifu_skid_fifo
   import ifu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_push,
   input  ifu_entry_t i_entry,
   input  logic       i_pop,
   input  logic       i_flush,
   output ifu_entry_t o_head,
   output logic [1:0] o_count
);

   ifu_entry_t r_head;
   ifu_entry_t r_tail;
   logic [1:0] r_count;

   // Shift organisation: the head register always holds the oldest entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 2'd0;
      end else if (i_flush) begin
         r_count <= 2'd0;
      end else begin
         case ({i_push, i_pop})
            2'b10: begin
               if (r_count == 2'd0) r_head <= i_entry;
               else                 r_tail <= i_entry;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_head  <= r_tail;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd2) begin
                  r_head <= r_tail;
                  r_tail <= i_entry;
               end else begin
                  r_head <= i_entry;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_head  = r_head;
   assign o_count = r_count;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational ROM and buffers
// fetched words for decode. Define IFU_PERF_CNT_EN to add fetch/flush counters.
module ifetch_unit
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int unsigned ADDR_W   = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [31:0]       id_pc,
   output logic [31:0]       id_ins
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_flush_cnt
`endif
);

   ifu_state_e r_state;
   logic [31:0] r_pc;
   logic        w_pop;
   logic        w_fire;
   logic [1:0]  w_count;
   ifu_entry_t  w_head;
   ifu_entry_t  w_push_entry;

   assign rom_addr     = r_pc[ADDR_W+1:2];
   assign id_valid     = (w_count != 2'd0);
   assign w_pop        = id_valid & id_ready;
   assign w_fire       = (r_state == RUN) & ~redirect_valid & ((w_count != 2'd2) | w_pop);
   assign w_push_entry = '{pc: r_pc, ins: rom_data};
   assign id_pc        = id_valid ? w_head.pc  : 32'h0000_0000;
   assign id_ins       = id_valid ? w_head.ins : INS_NOP;

   // BOOT lasts exactly one cycle; a redirect is honoured even there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= BOOT;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= RUN;
         if (redirect_valid) r_pc <= redirect_pc & ~32'h0000_0003;
         else if (w_fire)    r_pc <= r_pc + 32'd4;
      end
   end

   ifu_skid_fifo u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_fire),
      .i_entry (w_push_entry),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .o_head  (w_head),
      .o_count (w_count)
   );

`ifdef IFU_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_cnt <= 32'd0;
         r_flush_cnt <= 32'd0;
      end else begin
         if (w_fire)         r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (redirect_valid) r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign perf_fetch_cnt = r_fetch_cnt;
   assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed, table-driven bench for ifetch_unit; ROM word i holds value i.
// Build with IFU_PERF_CNT_EN defined to also check the perf counters.
module tb_ifetch_unit;
   import ifu_pkg::*;

   localparam int unsigned ADDR_W = 14;
   localparam int unsigned NVEC   = 31;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_data;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              id_valid;
   logic              id_ready;
   logic [31:0]       id_pc;
   logic [31:0]       id_ins;
`ifdef IFU_PERF_CNT_EN
   logic [31:0]       perf_fetch_cnt;
   logic [31:0]       perf_flush_cnt;
`endif

   int n_pass;
   int n_total;

   typedef struct {
      bit              rst;
      bit              rv;
      logic [31:0]     rpc;
      bit              rdy;
      bit              ev;
      logic [31:0]     epc;
      logic [31:0]     eins;
      logic [ADDR_W-1:0] eaddr;
   } vec_t;

   vec_t vecs [NVEC];
   int   nv;

   ifetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_ins         (id_ins)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   assign rom_data = 32'(rom_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total = n_total + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic add(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy,
                      input bit ev, input logic [31:0] epc, input logic [31:0] eins,
                      input logic [ADDR_W-1:0] eaddr);
      vecs[nv] = '{rst: rst, rv: rv, rpc: rpc, rdy: rdy, ev: ev, epc: epc, eins: eins, eaddr: eaddr};
      nv = nv + 1;
   endtask

   // Leaves the bench at a falling edge with the DUT in its BOOT cycle.
   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      id_ready       = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      nv      = 0;
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      id_ready       = 1'b0;

      // Straight-line fetch after reset
      add(1, 0, 0, 1, 0, 32'h0,  INS_NOP, 14'h0);
      add(0, 0, 0, 1, 0, 32'h0,  INS_NOP, 14'h0);
      add(0, 0, 0, 1, 1, 32'h0,  32'h0,   14'h1);
      add(0, 0, 0, 1, 1, 32'h4,  32'h1,   14'h2);
      add(0, 0, 0, 1, 1, 32'h8,  32'h2,   14'h3);
      add(0, 0, 0, 1, 1, 32'hC,  32'h3,   14'h4);
      // Back-pressure: fill both entries then stall
      add(1, 0, 0, 0, 0, 32'h0,  INS_NOP, 14'h0);
      add(0, 0, 0, 0, 0, 32'h0,  INS_NOP, 14'h0);
      add(0, 0, 0, 0, 1, 32'h0,  32'h0,   14'h1);
      add(0, 0, 0, 0, 1, 32'h0,  32'h0,   14'h2);
      add(0, 0, 0, 0, 1, 32'h0,  32'h0,   14'h2);
      add(0, 0, 0, 0, 1, 32'h0,  32'h0,   14'h2);
      add(0, 0, 0, 0, 1, 32'h0,  32'h0,   14'h2);
      add(0, 0, 0, 1, 1, 32'h0,  32'h0,   14'h2);
      add(0, 0, 0, 1, 1, 32'h4,  32'h1,   14'h3);
      add(0, 0, 0, 0, 1, 32'h8,  32'h2,   14'h4);
      // Redirect with a full buffer, low pc bits cleared
      add(0, 1, 32'h0000_0103, 0, 1, 32'h8, 32'h2, 14'h4);
      add(0, 0, 0, 1, 0, 32'h0,   INS_NOP, 14'h40);
      add(0, 0, 0, 1, 1, 32'h100, 32'h40,  14'h41);
      add(0, 0, 0, 0, 1, 32'h104, 32'h41,  14'h42);
      // Redirect coinciding with a pop at count 2
      add(0, 1, 32'h0000_0200, 1, 1, 32'h104, 32'h41, 14'h43);
      add(0, 0, 0, 1, 0, 32'h0,   INS_NOP, 14'h80);
      add(0, 0, 0, 1, 1, 32'h200, 32'h80,  14'h81);
      // PC wrap at the top of the address space
      add(0, 1, 32'hFFFF_FFF8, 1, 1, 32'h204, 32'h81, 14'h82);
      add(0, 0, 0, 1, 0, 32'h0,         INS_NOP,  14'h3FFE);
      add(0, 0, 0, 1, 1, 32'hFFFF_FFF8, 32'h3FFE, 14'h3FFF);
      add(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'h3FFF, 14'h0000);
      add(0, 0, 0, 1, 1, 32'h0000_0000, 32'h0,    14'h0001);
      // Redirect during the BOOT cycle
      add(1, 1, 32'h0000_0040, 1, 0, 32'h0,  INS_NOP, 14'h00);
      add(0, 0, 0, 1, 0, 32'h0,  INS_NOP, 14'h10);
      add(0, 0, 0, 1, 1, 32'h40, 32'h10,  14'h11);

      for (int i = 0; i < nv; i++) begin
         if (vecs[i].rst) do_reset();
         chk($sformatf("v%0d.id_valid", i), 32'(id_valid), 32'(vecs[i].ev));
         chk($sformatf("v%0d.id_ins", i), id_ins, vecs[i].eins);
         chk($sformatf("v%0d.rom_addr", i), 32'(rom_addr), 32'(vecs[i].eaddr));
         if (vecs[i].ev) chk($sformatf("v%0d.id_pc", i), id_pc, vecs[i].epc);
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         id_ready       = vecs[i].rdy;
         @(negedge clk);
      end

      // Asynchronous reset in the middle of a stream
      do_reset();
      id_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid.pre_valid", 32'(id_valid), 32'h1);
      chk("mid.pre_pc", id_pc, 32'h8);
`ifdef IFU_PERF_CNT_EN
      chk("mid.pre_fetch_cnt", perf_fetch_cnt, 32'd3);
      chk("mid.pre_flush_cnt", perf_flush_cnt, 32'd0);
`endif
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid.rst_valid", 32'(id_valid), 32'h0);
      chk("mid.rst_ins", id_ins, INS_NOP);
      chk("mid.rst_addr", 32'(rom_addr), 32'h0);
`ifdef IFU_PERF_CNT_EN
      chk("mid.rst_fetch_cnt", perf_fetch_cnt, 32'd0);
      chk("mid.rst_flush_cnt", perf_flush_cnt, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid.boot_valid", 32'(id_valid), 32'h0);
      @(negedge clk);
      chk("mid.run_valid", 32'(id_valid), 32'h0);
      @(negedge clk);
      chk("mid.restart_valid", 32'(id_valid), 32'h1);
      chk("mid.restart_pc", id_pc, 32'h0);
      chk("mid.restart_ins", id_ins, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
